// File: rtl/ocp_pkg.sv
// Shared OCP encodings: command, response and initiator FSM states.
package ocp_pkg;

  typedef enum logic [1:0] {
    S_CMD_IDLE  = 2'd0,
    S_CMD_WRITE = 2'd1,
    S_CMD_READ  = 2'd2
  } cmd_t;

  typedef enum logic [1:0] {
    S_RESP_NULL = 2'd0,
    S_RESP_DVA  = 2'd1,
    S_RESP_ERR  = 2'd2
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Command code presented on the bus for a captured request.
  function automatic cmd_t cmd_for(input logic write);
    return write ? S_CMD_WRITE : S_CMD_READ;
  endfunction

endpackage

// File: rtl/ocp_if.sv
// OCP request/response bundle between one master and one slave.
interface ocp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  ocp_pkg::cmd_t           s_cmd;
  logic [ADDR_WIDTH-1:0]   s_addr;
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_cmd_accept;
  ocp_pkg::resp_t          s_resp;
  logic [DATA_WIDTH-1:0]   s_resp_data;

  modport master (
    output s_cmd, s_addr, s_data,
    input  s_cmd_accept, s_resp, s_resp_data
  );

  modport slave (
    input  s_cmd, s_addr, s_data,
    output s_cmd_accept, s_resp, s_resp_data
  );
endinterface

// File: rtl/ocp_resp_timer.sv
// Saturating counter of cycles spent waiting for a slave response.
module ocp_resp_timer #(
  parameter int RESP_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] MAX  = CW'(RESP_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(RESP_TIMEOUT - 1);

  logic [CW-1:0] count;

  // Held at zero outside the wait so every wait starts from zero; saturates at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (!run)
      count <= '0;
    else if (count != MAX)
      count <= count + 1'b1;
  end

  // Asserted during the final permitted waiting cycle.
  assign expired = run && (count == LAST);

endmodule

// File: rtl/ocp_master_initiator.sv
// Single-outstanding OCP initiator: local request -> bus command -> response.
module ocp_master_initiator
  import ocp_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int RESP_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  ocp_if.master                 m_ocp,
  output logic                  busy
);

  state_t                state_q, state_d;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  load_req, load_rsp, load_tmo;
  logic                  tmo_expired;

  ocp_resp_timer #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (state_q == RESP),
    .expired (tmo_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, bus drive and capture strobes.
  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    load_req      = 1'b0;
    load_rsp      = 1'b0;
    load_tmo      = 1'b0;
    m_ocp.s_cmd   = S_CMD_IDLE;
    m_ocp.s_addr  = '0;
    m_ocp.s_data  = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = enable;
        if (req_valid && enable) begin
          load_req = 1'b1;
          state_d  = CMD;
        end
      end
      CMD: begin
        m_ocp.s_cmd  = cmd_for(wr_q);
        m_ocp.s_addr = addr_q;
        m_ocp.s_data = wdata_q;
        // A response in the accept cycle completes without visiting RESP.
        if (m_ocp.s_cmd_accept) begin
          if (m_ocp.s_resp != S_RESP_NULL) begin
            load_rsp = 1'b1;
            state_d  = DONE;
          end else begin
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (m_ocp.s_resp != S_RESP_NULL) begin
          load_rsp = 1'b1;
          state_d  = DONE;
        end else if (tmo_expired) begin
          load_tmo = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request and completion capture; completion values hold until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (load_req) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (load_rsp) begin
        rdata_q <= (m_ocp.s_resp == S_RESP_DVA && !wr_q) ? m_ocp.s_resp_data : '0;
        err_q   <= (m_ocp.s_resp != S_RESP_DVA);
      end else if (load_tmo) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ocp_master_initiator.sv
// Directed bench for ocp_master_initiator with a transaction-level reference model.
module tb_ocp_master_initiator;
  import ocp_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          busy;

  ocp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ocp_master_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .m_ocp     (bus),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: one request in flight, tracked by flags and a wait count.
  bit          m_active, m_issued, m_done, m_write, m_err;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_wdata, m_rdata;
  int          m_wait;
  bit          respond, give_up;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 0; m_issued <= 0; m_done <= 0; m_write <= 0; m_err <= 0;
      m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_wait <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (!m_active) begin
      if (enable && req_valid) begin
        m_active <= 1; m_issued <= 0;
        m_write <= req_write; m_addr <= req_addr; m_wdata <= req_wdata;
      end
    end else begin
      respond = (bus.s_resp != S_RESP_NULL) && (m_issued || bus.s_cmd_accept);
      give_up = m_issued && !respond && (m_wait + 1 == TMO);
      if (!m_issued && bus.s_cmd_accept && !respond) begin
        m_issued <= 1; m_wait <= 0;
      end
      if (m_issued) m_wait <= m_wait + 1;
      if (respond || give_up) begin
        m_active <= 0; m_done <= 1;
        m_err    <= give_up || (bus.s_resp != S_RESP_DVA);
        m_rdata  <= (respond && bus.s_resp == S_RESP_DVA && !m_write) ? bus.s_resp_data : '0;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int done_count = 0, last_done_cyc = 0, cmd_cycles = 0, ready_cycles = 0;
  logic [DW-1:0] last_rdata = '0;
  logic          last_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model, plus observation tallies.
  task automatic compare();
    bit in_cmd;
    cmd_t ecmd;
    in_cmd = m_active && !m_issued;
    ecmd   = !in_cmd ? S_CMD_IDLE : (m_write ? S_CMD_WRITE : S_CMD_READ);
    chk("busy", 64'(busy), 64'(m_active || m_done));
    chk("req_ready", 64'(req_ready), 64'(!m_active && !m_done && enable));
    chk("s_cmd", 64'(bus.s_cmd), 64'(ecmd));
    chk("s_addr", 64'(bus.s_addr), in_cmd ? 64'(m_addr) : 64'd0);
    chk("s_data", 64'(bus.s_data), in_cmd ? 64'(m_wdata) : 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'(m_done));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
    chk("rsp_error", 64'(rsp_error), 64'(m_err));
    if (rsp_valid) begin
      done_count++; last_done_cyc = cyc; last_rdata = rsp_rdata; last_err = rsp_error;
    end
    if (bus.s_cmd != S_CMD_IDLE) cmd_cycles++;
    if (req_ready) ready_cycles++;
  endtask

  task automatic half();
    @(negedge clk);
    compare();
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    rise();
  endtask

  task automatic request(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
  endtask

  task automatic slave(input logic acc, input resp_t r, input logic [DW-1:0] d);
    bus.s_cmd_accept = acc; bus.s_resp = r; bus.s_resp_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, base_done, base_cmd, base_ready;
    slave(1'b0, S_RESP_NULL, '0);
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_cmd", 64'(bus.s_cmd), 64'(S_CMD_IDLE));
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // Read addr 5, immediate accept, DVA two cycles later.
    base_done = done_count; t0 = cyc;
    request(1'b0, 5'd5, '0);
    rise();
    req_valid = 1'b0; slave(1'b1, S_RESP_NULL, '0);
    half();
    chk("rd_cmd", 64'(bus.s_cmd), 64'(S_CMD_READ));
    chk("rd_addr", 64'(bus.s_addr), 64'd5);
    rise();
    slave(1'b0, S_RESP_NULL, '0); tick();
    slave(1'b0, S_RESP_DVA, 32'hDEADBEEF); tick();
    slave(1'b0, S_RESP_NULL, '0); tick(); tick(); tick();
    chk("rd_pulses", 64'(done_count - base_done), 64'd1);
    chk("rd_latency", 64'(last_done_cyc - t0), 64'd4);
    chk("rd_rdata", 64'(last_rdata), 64'hDEADBEEF);
    chk("rd_error", 64'(last_err), 64'd0);

    // Write with accept delayed four cycles.
    base_done = done_count; base_cmd = cmd_cycles; t0 = cyc;
    request(1'b1, 5'd3, 32'h12345678);
    rise();
    req_valid = 1'b0;
    repeat (4) tick();
    slave(1'b1, S_RESP_NULL, '0); tick();
    slave(1'b0, S_RESP_DVA, 32'hAAAA5555); tick();
    slave(1'b0, S_RESP_NULL, '0); tick(); tick(); tick();
    chk("wr_cmd_cycles", 64'(cmd_cycles - base_cmd), 64'd5);
    chk("wr_latency", 64'(last_done_cyc - t0), 64'd7);
    chk("wr_rdata", 64'(last_rdata), 64'd0);
    chk("wr_error", 64'(last_err), 64'd0);

    // Same-cycle accept + ERR, then back-to-back read; stray responses in DONE/IDLE.
    base_done = done_count; t0 = cyc;
    request(1'b0, 5'd9, '0);
    rise();
    slave(1'b1, S_RESP_ERR, 32'h00001111); tick();
    slave(1'b0, S_RESP_DVA, 32'h00000BAD);
    half();
    chk("err_valid", 64'(rsp_valid), 64'd1);
    chk("err_error", 64'(rsp_error), 64'd1);
    chk("err_rdata", 64'(rsp_rdata), 64'd0);
    chk("err_ready_in_done", 64'(req_ready), 64'd0);
    rise();
    half();
    chk("b2b_ready", 64'(req_ready), 64'd1);
    rise();
    req_valid = 1'b0; slave(1'b1, S_RESP_DVA, 32'hCAFEF00D); tick();
    slave(1'b0, S_RESP_NULL, '0); tick(); tick(); tick();
    chk("b2b_pulses", 64'(done_count - base_done), 64'd2);
    chk("b2b_latency", 64'(last_done_cyc - t0), 64'd5);
    chk("b2b_rdata", 64'(last_rdata), 64'hCAFEF00D);

    // Slave accepts and never responds.
    base_done = done_count; t0 = cyc;
    request(1'b0, 5'd12, '0);
    rise();
    req_valid = 1'b0; slave(1'b1, S_RESP_NULL, 32'hFFFFFFFF); tick();
    slave(1'b0, S_RESP_NULL, 32'hFFFFFFFF);
    repeat (20) tick();
    chk("tmo_pulses", 64'(done_count - base_done), 64'd1);
    chk("tmo_latency", 64'(last_done_cyc - t0), 64'(TMO + 2));
    chk("tmo_error", 64'(last_err), 64'd1);
    chk("tmo_rdata", 64'(last_rdata), 64'd0);
    slave(1'b0, S_RESP_NULL, '0);

    // Enable drops during RESP; transaction still completes, nothing new accepted.
    base_done = done_count; t0 = cyc;
    request(1'b0, 5'd2, '0);
    rise();
    req_valid = 1'b0; slave(1'b1, S_RESP_NULL, '0); tick();
    slave(1'b0, S_RESP_NULL, '0); enable = 1'b0; request(1'b0, 5'd30, '0);
    base_ready = ready_cycles;
    tick(); tick();
    slave(1'b0, S_RESP_DVA, 32'h0BADCAFE); tick();
    slave(1'b0, S_RESP_NULL, '0); tick(); tick(); tick();
    chk("en_ready_low", 64'(ready_cycles - base_ready), 64'd0);
    req_valid = 1'b0; enable = 1'b1;
    half();
    chk("en_ready_back", 64'(req_ready), 64'd1);
    rise();
    chk("en_pulses", 64'(done_count - base_done), 64'd1);
    chk("en_latency", 64'(last_done_cyc - t0), 64'd5);
    chk("en_rdata", 64'(last_rdata), 64'h0BADCAFE);

    // Reset while the command is on the bus.
    request(1'b0, 5'd4, '0);
    rise();
    req_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_cmd", 64'(bus.s_cmd), 64'(S_CMD_IDLE));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    base_done = done_count;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_no_pulse", 64'(done_count - base_done), 64'd0);
    t0 = cyc;
    request(1'b0, 5'd6, '0);
    rise();
    req_valid = 1'b0; slave(1'b1, S_RESP_DVA, 32'h600D600D); tick();
    slave(1'b0, S_RESP_NULL, '0); tick(); tick(); tick();
    chk("post_rst_pulses", 64'(done_count - base_done), 64'd1);
    chk("post_rst_latency", 64'(last_done_cyc - t0), 64'd2);
    chk("post_rst_rdata", 64'(last_rdata), 64'h600D600D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ocp_master_initiator.md
OCP_MASTER_INITIATOR -- requirements
Module: ocp_master_initiator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the write and read data words.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, width of the word address.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 15, maximum number of RESP-state cycles before the initiator flags an error.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  when high, new local requests may be accepted.
REQ-008 req_valid  input  1  local request present.
REQ-009 req_ready  output  1  local request accepted this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_WIDTH  request word address.
REQ-012 req_wdata  input  DATA_WIDTH  write data.
REQ-013 rsp_valid  output  1  one-cycle completion pulse.
REQ-014 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-015 rsp_error  output  1  completion carried S_RESP_ERR or timed out.
REQ-016 m_ocp  interface  ocp_if.master  OCP port; drives s_cmd, s_addr, s_data; samples s_cmd_accept, s_resp, s_resp_data.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, CMD, RESP and DONE.
REQ-019 SHALL assert req_ready combinationally as (state==IDLE && enable); on req_valid && req_ready it captures write/addr/wdata and moves to CMD.
REQ-020 In CMD: s_cmd = S_CMD_WRITE or S_CMD_READ, s_addr/s_data held stable from captured values; stays in CMD until s_cmd_accept sampled high, then to RESP.
REQ-021 In every state other than CMD: s_cmd = S_CMD_IDLE, s_addr and s_data = 0.
REQ-022 Writes are non-posted: both reads and writes SHALL wait for s_resp != S_RESP_NULL.
REQ-023 If s_cmd_accept and a non-NULL s_resp are sampled in the same CMD cycle, the response SHALL be captured and the FSM SHALL go directly to DONE.
REQ-024 In RESP: on S_RESP_DVA capture s_resp_data (reads only) with error=0; on S_RESP_ERR capture error=1 and rdata=0; then go to DONE.
REQ-025 A response counter SHALL clear on RESP entry and increment each RESP cycle; at RESP_TIMEOUT cycles without a response the FSM SHALL go to DONE with error=1 and rdata=0.
REQ-026 DONE lasts exactly one cycle: rsp_valid=1 with registered rsp_rdata/rsp_error; then IDLE. Outputs are held until the next DONE.
REQ-027 Minimum latency: accept at cycle 0, s_cmd driven at cycle 1, slave accept plus response at cycle 1, rsp_valid at cycle 2; back-to-back accept no earlier than the cycle after DONE.
REQ-028 Deasserting enable mid-transaction SHALL NOT abort it; only new acceptance is blocked.
REQ-029 Responses arriving in IDLE or DONE SHALL be ignored.
REQ-030 Counter width SHALL be $clog2(RESP_TIMEOUT+1) and SHALL saturate, never wrapping.

Reset
REQ-031 On reset assertion, asynchronously: state=IDLE, counter=0, captured registers=0.
REQ-032 During reset: rsp_valid=0, rsp_rdata=0, rsp_error=0, s_cmd=S_CMD_IDLE, busy=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no rsp_valid pulse.
REQ-034 The first request after reset release SHALL be accepted normally.

Structure
REQ-035 ocp_pkg SHALL hold the command enum (S_CMD_IDLE/WRITE/READ), the response enum (S_RESP_NULL/DVA/ERR) and the FSM state enum.
REQ-036 SHALL be a single module, optionally with one sub-module ocp_resp_timer holding the saturating timeout counter.

Verification
REQ-037 Read: addr=5, slave accepts at once, DVA with 0xDEADBEEF two cycles later -> rsp_valid one cycle, rsp_rdata=0xDEADBEEF, rsp_error=0.
REQ-038 Write 0x12345678 to addr=3, s_cmd_accept delayed 4 cycles -> s_cmd=WRITE, s_addr=3, s_data stable for 5 cycles; rsp_valid after DVA with rdata=0.
REQ-039 Same-cycle accept plus ERR response -> rsp_valid on the next cycle, rsp_error=1, rsp_rdata=0.
REQ-040 Slave accepts but never responds -> rsp_valid with rsp_error=1 exactly RESP_TIMEOUT cycles after RESP entry.
REQ-041 enable drops during RESP, then response arrives -> transaction completes; req_ready stays low while enable=0.
REQ-042 Reset asserted in CMD -> s_cmd=IDLE immediately, no rsp_valid, busy=0; the next read after release completes normally.
